// File: rtl/hsi_line_router_if.sv
// Bundle of configuration, HSI-line and transceiver-pin signals for hsi_line_router.
// The router takes the slave view; the board top level (or a bench) drives the master side.
interface hsi_line_router_if #(
    parameter int N_CH  = 22,
    parameter int N_SRC = 4
);
    logic             cfg_wr;
    logic [4:0]       cfg_ch;
    logic [1:0]       cfg_mode;
    logic [1:0]       cfg_src;
    logic             cfg_ack;
    logic [N_SRC-1:0] src;
    logic [N_SRC-1:0] rx_q;
    logic [N_CH-1:0]  line_r;
    logic [N_CH-1:0]  line_d;
    logic [N_CH-1:0]  line_de;
    logic [N_CH-1:0]  line_nre;
    logic [N_CH-1:0]  act;
    logic [N_CH-1:0]  lb_err;

    modport master (
        output cfg_wr, cfg_ch, cfg_mode, cfg_src, src, line_r,
        input  cfg_ack, rx_q, line_d, line_de, line_nre, act, lb_err
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_mode, cfg_src, src, line_r,
        output cfg_ack, rx_q, line_d, line_de, line_nre, act, lb_err
    );
endinterface

// File: rtl/hsi_line_router.sv
// Run-time configurable router between the HSI serial lines and half-duplex RS-485
// transceiver channels, with guarded driver turnaround, RX routing and loopback checking.
module hsi_line_router #(
    parameter int N_CH   = 22,
    parameter int N_SRC  = 4,
    parameter int GUARD  = 48,
    parameter int LB_DLY = 4
) (
    input  logic             clk,
    input  logic             rst,
    hsi_line_router_if.slave bus
);
    localparam int CW = $clog2(GUARD + 1);
    localparam int SW = $clog2(LB_DLY + 1);

    // Encodings 0..3 match cfg_mode so a mode converts to its state by zero-extension.
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_TX    = 3'd1,
        ST_RX    = 3'd2,
        ST_LOOP  = 3'd3,
        ST_GUARD = 3'd4
    } state_e;

    state_e            state_q [N_CH];
    state_e            state_d [N_CH];
    state_e            pend_q  [N_CH];
    state_e            pend_d  [N_CH];
    logic [1:0]        sel_q   [N_CH];
    logic [1:0]        sel_d   [N_CH];
    logic [CW-1:0]     cnt_q   [N_CH];
    logic [CW-1:0]     cnt_d   [N_CH];
    logic [SW-1:0]     sup_q   [N_CH];
    logic [SW-1:0]     sup_d   [N_CH];
    logic [LB_DLY-1:0] sh_q    [N_CH];
    logic [LB_DLY-1:0] sh_d    [N_CH];

    logic [N_CH-1:0]   s1_q, s2_q, s3_q;
    logic [N_CH-1:0]   act_q, act_d, lb_q, lb_d;
    logic [N_CH-1:0]   d_out, de_out, nre_out;
    logic [N_SRC-1:0]  src_q, route_q, route_d;
    logic              ack_q;

    // NOTE: every variable written in this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        logic   hit, edg, mism, drv, lsn;
        state_e new_mode;
        new_mode = state_e'({1'b0, bus.cfg_mode});
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            pend_d[c]  = pend_q[c];
            sel_d[c]   = sel_q[c];
            cnt_d[c]   = cnt_q[c];
            sup_d[c]   = sup_q[c];

            hit = bus.cfg_wr && (int'(bus.cfg_ch) == c);
            if (hit) begin
                sel_d[c] = bus.cfg_src;
                // Any write while guarding restarts the full guard period.
                if (state_q[c] == ST_GUARD || new_mode != state_q[c]) begin
                    state_d[c] = ST_GUARD;
                    pend_d[c]  = new_mode;
                    cnt_d[c]   = CW'(GUARD);
                end
            end else if (state_q[c] == ST_GUARD) begin
                if (cnt_q[c] <= CW'(1)) begin
                    state_d[c] = pend_q[c];
                    cnt_d[c]   = '0;
                end else begin
                    cnt_d[c] = cnt_q[c] - CW'(1);
                end
            end

            drv        = (state_q[c] == ST_TX) || (state_q[c] == ST_LOOP);
            lsn        = (state_q[c] == ST_RX) || (state_q[c] == ST_LOOP);
            d_out[c]   = drv & src_q[sel_q[c]];
            de_out[c]  = drv;
            nre_out[c] = ~lsn;

            edg  = s2_q[c] ^ s3_q[c];
            mism = (state_q[c] == ST_LOOP) && (sup_q[c] == '0) &&
                   (s2_q[c] != sh_q[c][LB_DLY-1]);
            act_d[c] = act_q[c] | (edg & lsn);
            lb_d[c]  = lb_q[c] | mism;
            if (hit) begin
                act_d[c] = 1'b0;
                lb_d[c]  = 1'b0;
            end

            // Loopback echo needs LB_DLY cycles to settle after entering LOOP or rebinding.
            sh_d[c] = {sh_q[c][LB_DLY-2:0], d_out[c]};
            if (state_d[c] == ST_LOOP && (state_q[c] != ST_LOOP || sel_d[c] != sel_q[c])) begin
                sup_d[c] = SW'(LB_DLY);
            end else if (sup_q[c] != '0) begin
                sup_d[c] = sup_q[c] - SW'(1);
            end
        end
    end

    // Scanning from the top down lets the lowest-index RX channel overwrite the others.
    always_comb begin
        route_d = '0;
        for (int s = 0; s < N_SRC; s++) begin
            for (int c = N_CH - 1; c >= 0; c--) begin
                if (state_q[c] == ST_RX && int'(sel_q[c]) == s) begin
                    route_d[s] = s2_q[c];
                end
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= ST_OFF;
                pend_q[c]  <= ST_OFF;
                sel_q[c]   <= '0;
                cnt_q[c]   <= '0;
                sup_q[c]   <= '0;
                sh_q[c]    <= '0;
            end
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            act_q   <= '0;
            lb_q    <= '0;
            src_q   <= '0;
            route_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                pend_q[c]  <= pend_d[c];
                sel_q[c]   <= sel_d[c];
                cnt_q[c]   <= cnt_d[c];
                sup_q[c]   <= sup_d[c];
                sh_q[c]    <= sh_d[c];
            end
            s1_q    <= bus.line_r;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            act_q   <= act_d;
            lb_q    <= lb_d;
            src_q   <= bus.src;
            route_q <= route_d;
            ack_q   <= bus.cfg_wr;
        end
    end

    assign bus.line_d   = d_out;
    assign bus.line_de  = de_out;
    assign bus.line_nre = nre_out;
    assign bus.act      = act_q;
    assign bus.lb_err   = lb_q;
    assign bus.rx_q     = route_q;
    assign bus.cfg_ack  = ack_q;
endmodule
